// File: rtl/halut_pkg.sv
// Shared defaults, derived widths and the accumulate helper for the Halut decoder bank.
package halut_pkg;

  localparam int unsigned DefDecoderUnits   = 16;
  localparam int unsigned DefK              = 16;
  localparam int unsigned DefC              = 32;
  localparam int unsigned DefDataTypeWidth  = 16;
  localparam int unsigned AccWidth          = 32;

  localparam int unsigned DefDecAddrWidth   = $clog2(DefDecoderUnits);
  localparam int unsigned DefTotalAddrWidth = $clog2(DefC * DefK);
  localparam int unsigned DefCAddrWidth     = $clog2(DefC);
  localparam int unsigned DefTreeDepth      = $clog2(DefK);

  // Adds two 32-bit signed values; when sat is set, an overflow clamps to the
  // signed limit in the direction of the operands instead of wrapping.
  function automatic logic [AccWidth-1:0] acc_add(input logic [AccWidth-1:0] a,
                                                  input logic [AccWidth-1:0] b,
                                                  input logic sat);
    logic [AccWidth-1:0] s;
    s = a + b;
    if (sat && (a[AccWidth-1] == b[AccWidth-1]) && (s[AccWidth-1] != a[AccWidth-1])) begin
      s = a[AccWidth-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
    return s;
  endfunction

endpackage

// File: rtl/halut_decoder_lane.sv
// One decoder lane: private LUT, registered read and row accumulator.
// HALUT_DEC_SATURATE_EN selects saturating instead of wrapping accumulation.
module halut_decoder_lane
  import halut_pkg::*;
#(
  parameter int unsigned K             = DefK,
  parameter int unsigned C             = DefC,
  parameter int unsigned DataTypeWidth = DefDataTypeWidth,
  localparam int unsigned TotalAddrWidth = $clog2(C * K)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      we_i,
  input  logic [TotalAddrWidth-1:0] waddr_i,
  input  logic [DataTypeWidth-1:0]  wdata_i,
  input  logic                      rd_en_i,
  input  logic [TotalAddrWidth-1:0] raddr_i,
  input  logic                      acc_en_i,
  input  logic                      acc_clear_i,
  output logic [AccWidth-1:0]       acc_next_o
);

`ifdef HALUT_DEC_SATURATE_EN
  localparam logic SatEn = 1'b1;
`else
  localparam logic SatEn = 1'b0;
`endif

  logic [DataTypeWidth-1:0]        r_lut [C*K];
  logic [DataTypeWidth-1:0]        r_rdata;
  logic [AccWidth-1:0]             r_acc;
  logic signed [DataTypeWidth-1:0] w_entry;
  logic [AccWidth-1:0]             w_ext;

  // LUT storage is not reset; a same-address read during a write sees the old entry.
  always_ff @(posedge clk_i) begin
    if (we_i) r_lut[waddr_i] <= wdata_i;
    if (rd_en_i) r_rdata <= r_lut[raddr_i];
  end

  assign w_entry    = r_rdata;
  assign w_ext      = AccWidth'(w_entry);
  assign acc_next_o = acc_clear_i ? w_ext : acc_add(r_acc, w_ext, SatEn);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
    end else if (acc_en_i) begin
      r_acc <= acc_next_o;
    end
  end

endmodule

// File: rtl/halut_decoder_x_bank.sv
// Bank of Halut decoder lanes sharing one encoder stream; streams row results lane by lane.
// HALUT_DEC_SATURATE_EN (in the lanes) selects saturating accumulation.
module halut_decoder_x_bank
  import halut_pkg::*;
#(
  parameter int unsigned DecoderUnits  = DefDecoderUnits,
  parameter int unsigned K             = DefK,
  parameter int unsigned C             = DefC,
  parameter int unsigned DataTypeWidth = DefDataTypeWidth,
  localparam int unsigned DecAddrWidth   = $clog2(DecoderUnits),
  localparam int unsigned TotalAddrWidth = $clog2(C * K),
  localparam int unsigned CAddrWidth     = $clog2(C),
  localparam int unsigned TreeDepth      = $clog2(K)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DecAddrWidth-1:0]   m_addr_i,
  input  logic [TotalAddrWidth-1:0] waddr_i,
  input  logic [DataTypeWidth-1:0]  wdata_i,
  input  logic                      we_i,
  input  logic [CAddrWidth-1:0]     c_addr_i,
  input  logic [TreeDepth-1:0]      k_addr_i,
  input  logic                      decoder_i,
  output logic [AccWidth-1:0]       result_o,
  output logic                      valid_o,
  output logic [DecAddrWidth-1:0]   m_addr_o
);

  localparam int unsigned CntWidth = DecAddrWidth + 1;

  logic                  r_rd_valid;
  logic [CAddrWidth-1:0] r_c_tag;
  logic [AccWidth-1:0]   r_buf [DecoderUnits];
  logic [CntWidth-1:0]   r_cnt;
  logic [AccWidth-1:0]   w_acc_next [DecoderUnits];
  logic                  w_complete;
  logic                  w_acc_clear;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_valid <= 1'b0;
      r_c_tag    <= '0;
    end else begin
      r_rd_valid <= decoder_i;
      if (decoder_i) r_c_tag <= c_addr_i;
    end
  end

  assign w_acc_clear = (r_c_tag == '0);
  assign w_complete  = r_rd_valid && (r_c_tag == CAddrWidth'(C - 1));

  for (genvar g = 0; g < DecoderUnits; g++) begin : g_lane
    halut_decoder_lane #(
      .K             (K),
      .C             (C),
      .DataTypeWidth (DataTypeWidth)
    ) u_lane (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .we_i        (we_i && (m_addr_i == DecAddrWidth'(g))),
      .waddr_i     (waddr_i),
      .wdata_i     (wdata_i),
      .rd_en_i     (decoder_i),
      .raddr_i     ({c_addr_i, k_addr_i}),
      .acc_en_i    (r_rd_valid),
      .acc_clear_i (w_acc_clear),
      .acc_next_o  (w_acc_next[g])
    );
  end

  // valid_o is a pure valid (no ready): each high cycle carries one lane's
  // result_o tagged by m_addr_o, lanes 0..DecoderUnits-1 in order. On completion
  // lane 0 goes straight out, so r_cnt holds the index of the next lane to send.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DecoderUnits; i++) r_buf[i] <= '0;
      r_cnt    <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
      m_addr_o <= '0;
    end else if (w_complete) begin
      for (int i = 0; i < DecoderUnits; i++) r_buf[i] <= w_acc_next[i];
      valid_o  <= 1'b1;
      result_o <= w_acc_next[0];
      m_addr_o <= '0;
      r_cnt    <= CntWidth'(1);
    end else if (valid_o) begin
      if (r_cnt == CntWidth'(DecoderUnits)) begin
        valid_o <= 1'b0;
      end else begin
        result_o <= r_buf[r_cnt[DecAddrWidth-1:0]];
        m_addr_o <= r_cnt[DecAddrWidth-1:0];
        r_cnt    <= r_cnt + CntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_halut_decoder_x_bank.sv
// Directed, table-driven bench for halut_decoder_x_bank with a lane-result scoreboard.
module tb_halut_decoder_x_bank;
  import halut_pkg::*;

  localparam int DU  = DefDecoderUnits;
  localparam int K   = DefK;
  localparam int C   = DefC;
  localparam int DW  = DefDataTypeWidth;
  localparam int DAW = DefDecAddrWidth;
  localparam int TAW = DefTotalAddrWidth;
  localparam int CAW = DefCAddrWidth;
  localparam int TD  = DefTreeDepth;

  logic           clk_i;
  logic           rst_ni;
  logic [DAW-1:0] m_addr_i;
  logic [TAW-1:0] waddr_i;
  logic [DW-1:0]  wdata_i;
  logic           we_i;
  logic [CAW-1:0] c_addr_i;
  logic [TD-1:0]  k_addr_i;
  logic           decoder_i;
  logic [31:0]    result_o;
  logic           valid_o;
  logic [DAW-1:0] m_addr_o;

  halut_decoder_x_bank dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .m_addr_i  (m_addr_i),
    .waddr_i   (waddr_i),
    .wdata_i   (wdata_i),
    .we_i      (we_i),
    .c_addr_i  (c_addr_i),
    .k_addr_i  (k_addr_i),
    .decoder_i (decoder_i),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .m_addr_o  (m_addr_o)
  );

  // clock / reset
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard: {lane, result} in stream order
  logic [DAW+31:0] exp_q[$];
  logic [DAW+31:0] mon_e;

  typedef struct {
    int k;
    bit bubbles;
    bit chain;
    int base;
  } row_vec_t;

  row_vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: lane %0d result 0x%08h with nothing expected", m_addr_o, result_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("stream_lane", 32'(m_addr_o), 32'(mon_e[DAW+31:32]));
        check("stream_result", result_o, mon_e[31:0]);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic write_lut(input int lane, input int addr, input logic [DW-1:0] data);
    m_addr_i = DAW'(lane);
    waddr_i  = TAW'(addr);
    wdata_i  = data;
    we_i     = 1'b1;
    tick();
    we_i     = 1'b0;
  endtask

  task automatic push_row(input int base, input int step, input logic [31:0] lane0);
    for (int u = 0; u < DU; u++) begin
      exp_q.push_back({DAW'(u), (u == 0) ? lane0 : 32'(base + u * step)});
    end
  endtask

  task automatic send_row(input int k, input bit bubbles, input bit wr_first, input logic [DW-1:0] wdata);
    for (int c = 0; c < C; c++) begin
      c_addr_i  = CAW'(c);
      k_addr_i  = TD'(k);
      decoder_i = 1'b1;
      if (wr_first && c == 0) begin
        m_addr_i = '0;
        waddr_i  = TAW'(k);
        wdata_i  = wdata;
        we_i     = 1'b1;
      end
      tick();
      we_i = 1'b0;
      if (bubbles && c != C - 1) begin
        decoder_i = 1'b0;
        tick();
      end
    end
    decoder_i = 1'b0;
  endtask

  // called right after the last token edge: cycle n+1 idle, n+2..n+1+DU streaming
  task automatic check_timing();
    @(negedge clk_i);
    check("valid_before_stream", 32'(valid_o), 32'd0);
    for (int i = 0; i < DU; i++) begin
      @(negedge clk_i);
      check("valid_in_stream", 32'(valid_o), 32'd1);
      check("stream_order", 32'(m_addr_o), 32'(i));
    end
    @(negedge clk_i);
    check("valid_after_stream", 32'(valid_o), 32'd0);
  endtask

  initial begin
    // lane u result for one row at prototype k: 32 * (u+1) * (k+1)
    vecs[0] = '{k: 3,  bubbles: 1'b0, chain: 1'b0, base: 128};
    vecs[1] = '{k: 3,  bubbles: 1'b1, chain: 1'b0, base: 128};
    vecs[2] = '{k: 0,  bubbles: 1'b0, chain: 1'b0, base: 32};
    vecs[3] = '{k: 15, bubbles: 1'b0, chain: 1'b0, base: 512};
    vecs[4] = '{k: 7,  bubbles: 1'b0, chain: 1'b1, base: 256};
    vecs[5] = '{k: 1,  bubbles: 1'b0, chain: 1'b0, base: 64};

    rst_ni = 1'b0; m_addr_i = '0; waddr_i = '0; wdata_i = '0; we_i = 1'b0;
    c_addr_i = '0; k_addr_i = '0; decoder_i = 1'b0;
    repeat (3) tick();
    @(negedge clk_i);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    check("reset_m_addr", 32'(m_addr_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    repeat (2) tick();
    @(negedge clk_i);
    check("idle_valid", 32'(valid_o), 32'd0);
    check("idle_result", result_o, 32'd0);

    // LUT[u][c*K+k] = (u+1)*(k+1)
    for (int u = 0; u < DU; u++)
      for (int a = 0; a < C * K; a++)
        write_lut(u, a, DW'((u + 1) * ((a % K) + 1)));

    foreach (vecs[i]) begin
      push_row(vecs[i].base, vecs[i].base, 32'(vecs[i].base));
      send_row(vecs[i].k, vecs[i].bubbles, 1'b0, '0);
      if (!vecs[i].chain) check_timing();
    end

    // same-cycle write/read of lane 0 entry (c=0,k=5): old value 6 used, new 100 next row
    push_row(192, 192, 32'd192);
    send_row(5, 1'b0, 1'b1, 16'd100);
    check_timing();
    push_row(192, 192, 32'd286);
    send_row(5, 1'b0, 1'b0, '0);
    check_timing();

    // lane 0 all -1
    for (int a = 0; a < C * K; a++) write_lut(0, a, 16'hFFFF);
    push_row(128, 128, 32'hFFFF_FFE0);
    send_row(3, 1'b0, 1'b0, '0);
    check_timing();

    // all entries 0x7FFF: each row independently 32*32767
    for (int u = 0; u < DU; u++)
      for (int a = 0; a < C * K; a++)
        write_lut(u, a, 16'h7FFF);
    for (int r = 0; r < 3; r++) begin
      push_row(1048544, 0, 32'd1048544);
      send_row(r * 6, 1'b0, 1'b0, '0);
      check_timing();
    end

    // reset in the middle of a stream
    push_row(1048544, 0, 32'd1048544);
    send_row(2, 1'b0, 1'b0, '0);
    repeat (3) @(negedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    @(negedge clk_i);
    check("midreset_valid", 32'(valid_o), 32'd0);
    check("midreset_result", result_o, 32'd0);
    check("midreset_m_addr", 32'(m_addr_o), 32'd0);
    exp_q.delete();
    tick();
    rst_ni = 1'b1;
    tick();
    @(negedge clk_i);
    check("post_reset_valid", 32'(valid_o), 32'd0);

    // LUT contents survive reset
    push_row(1048544, 0, 32'd1048544);
    send_row(9, 1'b0, 1'b0, '0);
    check_timing();

    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
